// File: rtl/md_sched_pkg.sv
// md_sched_pkg: shared op codes, latency defaults and op-class helpers for the
// multiply/divide scheduler.
// Optional build macro: MD_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops.
package md_sched_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF  = 10;
  localparam int MD_CNT_W_DEF    = 4;

  // Ops that occupy the unit for a latency period and commit to HI/LO later.
  function automatic logic is_long_op(md_op_e op);
`ifdef MD_MADD_EN
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Anything other than NONE; unbuilt or undefined codes count as NONE.
  function automatic logic is_valid_op(md_op_e op);
    return is_long_op(op) || (op inside {MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO});
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: E-stage issue / result bundle between the pipeline (master)
// and the multiply/divide scheduler (slave).
interface md_sched_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  modport master (
    output start, md_op, rs_val, rt_val, d_is_md,
    input  busy, stall, md_rdata, hi, lo, err
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, d_is_md,
    output busy, stall, md_rdata, hi, lo, err
  );
endinterface

// File: rtl/md_sched_calc.sv
// md_calc: combinational 64-bit product / quotient / remainder for md_sched.
// Result is {res_hi, res_lo}; divides put the quotient in LO, remainder in HI.
// Optional build macro: MD_MADD_EN adds the accumulate inputs and MADD/MSUB ops.
module md_calc
  import md_sched_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
`ifdef MD_MADD_EN
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
`endif
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  // Sign-extended operands give the signed product in the low 64 bits.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // One unsigned divider serves both DIV (on magnitudes) and DIVU.
  // 0x8000_0000 / -1 falls out naturally: magnitude 2^31, same-sign quotient.
  assign signed_div = (op == MD_DIV);
  assign rs_mag     = rs_val[31] ? -rs_val : rs_val;
  assign rt_mag     = rt_val[31] ? -rt_val : rt_val;
  assign dvd        = signed_div ? rs_mag : rs_val;
  assign dvs        = signed_div ? rt_mag : rt_val;
  assign dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
  assign quo        = dvd / dvs_safe;
  assign rem        = dvd % dvs_safe;
  assign div_lo     = (signed_div && (rs_val[31] ^ rt_val[31])) ? -quo : quo;
  assign div_hi     = (signed_div && rs_val[31]) ? -rem : rem;

  // Result select per op, including the divide-by-zero rule
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (rt_val == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = rs_val;
        end else begin
          res_lo = div_lo;
          res_hi = div_hi;
        end
      end
`ifdef MD_MADD_EN
      MD_MADD:  {res_hi, res_lo} = {acc_hi, acc_lo} + prod_s;
      MD_MADDU: {res_hi, res_lo} = {acc_hi, acc_lo} + prod_u;
      MD_MSUB:  {res_hi, res_lo} = {acc_hi, acc_lo} - prod_s;
      MD_MSUBU: {res_hi, res_lo} = {acc_hi, acc_lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler. Owns HI/LO, runs the
// mult/div latency counter and raises the D-stage stall request.
// Optional build macro: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
//
// state | meaning
// IDLE  | nothing in flight; MTHI/MTLO write HI/LO directly
// RUN   | latency down-counter running; pend commits to HI/LO when cnt==1
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT_DEF,
  parameter int DIV_LAT  = MD_DIV_LAT_DEF,
  parameter int CNT_W    = MD_CNT_W_DEF
) (
  input logic       clk,
  input logic       reset_n,
  md_sched_if.slave md
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

  md_op_e           op;
  logic             long_op;
  logic             valid_op;
  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      rdata;
  logic             busy_q;
  logic             err_q;

  assign op       = md_op_e'(md.md_op);
  assign long_op  = is_long_op(op);
  assign valid_op = is_valid_op(op);

  md_calc u_calc (
    .op     (op),
    .rs_val (md.rs_val),
    .rt_val (md.rt_val),
`ifdef MD_MADD_EN
    .acc_hi (hi_q),
    .acc_lo (lo_q),
`endif
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  // FSM, latency counter, pending result, HI/LO and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.start) begin
            if (long_op) begin
              state   <= ST_RUN;
              busy_q  <= 1'b1;
              cnt     <= is_div_op(op) ? DIV_CNT : MULT_CNT;
              pend_hi <= calc_hi;
              pend_lo <= calc_lo;
            end else if (op == MD_MTHI) begin
              hi_q <= md.rs_val;
            end else if (op == MD_MTLO) begin
              lo_q <= md.rs_val;
            end
          end
        end
        ST_RUN: begin
          // Issue while busy is a hazard-logic bug: drop it, flag it.
          if (md.start && valid_op) begin
            err_q <= 1'b1;
          end
          if (cnt == CNT_TC) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt - CNT_TC;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  // MFHI/MFLO read port; zero for every other op
  always_comb begin
    rdata = '0;
    case (op)
      MD_MFHI: rdata = hi_q;
      MD_MFLO: rdata = lo_q;
      default: ;
    endcase
  end

  // Hold D while an op is in flight or one is being issued this cycle
  assign md.stall    = md.d_is_md & (busy_q | (md.start & long_op));
  assign md.busy     = busy_q;
  assign md.md_rdata = rdata;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.err      = err_q;

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the pipelined MIPS core.
- Owns HI/LO. Accepts MD ops issued from the E stage and runs a latency counter for mult/div.
- Commits results to HI/LO and raises the stall request the hazard logic uses to hold the D stage while an MD op is in flight.
- Sits beside the ALU in E and is configured by the decoded md_op from the control decoder.

Parameters:
- MULT_LAT, 5, cycles busy for mult/multu (and madd family); must be ≥1.
- DIV_LAT, 10, cycles busy for div/divu; must be ≥1.
- CNT_W, 4, counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is a valid MD op this cycle.
- md_op  in  4  op code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- d_is_md  in  1  D-stage instruction is any MD op (md_op≠NONE).
- busy  out  1  mult/div in progress.
- stall  out  1  hold D stage.
- md_rdata  out  32  MFHI/MFLO read data, combinational.
- hi  out  32  HI register.
- lo  out  32  LO register.
- err  out  1  sticky illegal-start flag.

Behaviour:
- Reset: hi=0, lo=0, busy=0, err=0, cnt=0, state=IDLE. Reset mid-operation discards the pending result.
- States:
  - IDLE → RUN on start with op in {MULT, MULTU, DIV, DIVU, MADD*, MSUB*} (MADD*/MSUB* only when MD_MADD_EN is defined).
  - On that transition, load cnt = MULT_LAT or DIV_LAT.
  - Latch the result into pend_hi/pend_lo in the same edge; the arithmetic is combinational on rs_val/rt_val.
  - RUN: cnt decrements each cycle. When cnt==1: hi/lo ← pend, state → IDLE.
  - busy = (state==RUN). busy is high for exactly LAT cycles after the start edge.
- MTHI/MTLO with start in IDLE: hi (or lo) ← rs_val at the next edge; no busy.
- MFHI/MFLO: md_rdata = hi or lo respectively. Commit writes are visible on the cycle after the commit edge. Otherwise md_rdata=0.
- stall = d_is_md & (busy | (start & md_op in mult/div set)).
  - The instruction following a mult/div is held until HI/LO are final.
  - MFHI/MFLO in D therefore never read stale data.
- start while busy (any op other than NONE): ignored; err←1 (sticky until reset). The hazard logic must prevent this.
- Arithmetic:
  - MULT: signed 32×32→64, {hi,lo}.
  - MULTU: unsigned.
  - DIV: lo=quotient, hi=remainder; truncate toward zero; remainder sign follows the dividend.
  - DIVU: unsigned.
- Divide by zero: lo=32'hFFFF_FFFF, hi=rs_val (DIV and DIVU).
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- MD_MADD_EN undefined → op codes 9..12 are treated as NONE.

Optional Feature:
- MD_MADD_EN defined:
  - MADD/MADDU: {hi,lo} ← {hi,lo} + rs*rt (signed/unsigned), 64-bit wrap.
  - MSUB/MSUBU: {hi,lo} ← {hi,lo} − rs*rt.
  - Accumulator value is sampled at the start edge; latency MULT_LAT.
- Not defined: the accumulate path is removed; op codes 9..12 are ignored, busy stays 0, no err.

Decomposition:
- Shared header (alongside existing op/funct `defines): md_op codes, MULT_LAT/DIV_LAT defaults.
- The control decoder gains an md_op output using these codes.
- Sub-module md_calc: pure combinational 64-bit product/quotient/remainder, including the div-by-zero and overflow rules. md_sched holds the FSM, counter, pend, hi/lo and stall.

Test Plan:
- MULT rs=32'hFFFF_FFFE (−2), rt=3 → busy high for 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA; busy low on cycle 6.
- DIVU rs=100, rt=7 with d_is_md=1 held → stall high for all 10 busy cycles; then lo=14, hi=2; MFHI md_rdata=2.
- DIV rs=−7, rt=2 → lo=−3, hi=−1. DIV rs=5, rt=0 → lo=32'hFFFF_FFFF, hi=5.
- MTHI rs=32'h1234_5678 → hi updated next edge, busy stays 0. A MULT start at cycle 2 of a prior DIV → ignored, err=1, DIV result intact.
- reset_n asserted at cycle 3 of a MULT → hi=lo=0, busy=0 immediately (asynchronous); no commit after release.
- MD_MADD_EN: hi=0, lo=10, MADD rs=3, rt=4 → lo=22 after 5 cycles. Without the macro, the same stimulus leaves lo=10, busy=0.
